// File: rtl/booth_mult_seq.sv
// Iterative signed radix-2 Booth multiplier: one add/sub/pass step and one arithmetic shift per clock.
// Optional macro BOOTH_UNSIGNED_EN adds an is_signed input that selects unsigned operands.
module booth_mult_seq #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
`ifdef BOOTH_UNSIGNED_EN
   input  logic                 is_signed,
`endif
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   // Unsigned mode runs one extra iteration over a zero-extended multiplier.
`ifdef BOOTH_UNSIGNED_EN
   localparam int QW = WIDTH + 1;
   localparam int CW = $clog2(WIDTH + 2);
`else
   localparam int QW = WIDTH;
   localparam int CW = $clog2(WIDTH + 1);
`endif

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH:0]       a_q, a_d;
   logic [WIDTH:0]       m_q, m_d;
   logic [QW-1:0]        q_q, q_d;
   logic                 qm1_q, qm1_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   product_q, product_d;
`ifdef BOOTH_UNSIGNED_EN
   logic                 signed_q, signed_d;
`endif

   logic [WIDTH:0]       a_sel;
   logic [WIDTH:0]       a_sh;
   logic [QW-1:0]        q_sh;
   logic                 qm1_sh;
   logic [2*WIDTH-1:0]   prod_sh;

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         a_q       <= '0;
         m_q       <= '0;
         q_q       <= '0;
         qm1_q     <= 1'b0;
         cnt_q     <= '0;
         product_q <= '0;
`ifdef BOOTH_UNSIGNED_EN
         signed_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         m_q       <= m_d;
         q_q       <= q_d;
         qm1_q     <= qm1_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
`ifdef BOOTH_UNSIGNED_EN
         signed_q  <= signed_d;
`endif
      end
   end

   // Booth step datapath: select, then arithmetic right shift of {A, Q, q_m1}.
   always_comb begin
      unique case ({q_q[0], qm1_q})
         2'b01:   a_sel = a_q + m_q;
         2'b10:   a_sel = a_q - m_q;
         default: a_sel = a_q;
      endcase
      a_sh   = {a_sel[WIDTH], a_sel[WIDTH:1]};
      q_sh   = {a_sel[0], q_q[QW-1:1]};
      qm1_sh = q_q[0];
`ifdef BOOTH_UNSIGNED_EN
      prod_sh = signed_q ? {a_sh[WIDTH-1:0], q_sh[QW-1:1]}
                         : {a_sh[WIDTH-2:0], q_sh};
`else
      prod_sh = {a_sh[WIDTH-1:0], q_sh};
`endif
   end

   // NOTE: every next-state signal gets its hold value first so no path infers a latch.
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      m_d       = m_q;
      q_d       = q_q;
      qm1_d     = qm1_q;
      cnt_d     = cnt_q;
      product_d = product_q;
`ifdef BOOTH_UNSIGNED_EN
      signed_d  = signed_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d   = '0;
               qm1_d = 1'b0;
`ifdef BOOTH_UNSIGNED_EN
               signed_d = is_signed;
               m_d      = {is_signed & multiplicand[WIDTH-1], multiplicand};
               q_d      = {is_signed & multiplier[WIDTH-1], multiplier};
               cnt_d    = is_signed ? CW'(WIDTH) : CW'(WIDTH + 1);
`else
               m_d      = {multiplicand[WIDTH-1], multiplicand};
               q_d      = multiplier;
               cnt_d    = CW'(WIDTH);
`endif
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            a_d   = a_sh;
            q_d   = q_sh;
            qm1_d = qm1_sh;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               product_d = prod_sh;
               state_d   = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign busy    = (state_q != S_IDLE);
   assign done    = (state_q == S_DONE);
   assign product = product_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: directed cases, exhaustive and random operands against
// a plain-arithmetic product model, plus start-ignore, mid-run reset and back-to-back throughput.
module tb_booth_mult_seq;

   localparam int W = 4;
`ifdef BOOTH_UNSIGNED_EN
   localparam bit HAS_U = 1'b1;
`else
   localparam bit HAS_U = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic [W-1:0]       multiplicand = '0;
   logic [W-1:0]       multiplier = '0;
   logic               is_signed = 1'b1;
   logic               busy;
   logic               done;
   logic [2*W-1:0]     product;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   booth_mult_seq #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
`ifdef BOOTH_UNSIGNED_EN
      .is_signed    (is_signed),
`endif
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no end, required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Reference: integer product of the operands read as signed or unsigned, truncated to 2W bits.
   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] m, input logic [W-1:0] q,
                                              input logic sgn);
      longint a, b, r;
      if (sgn) begin
         a = longint'($signed(m));
         b = longint'($signed(q));
      end else begin
         a = longint'(m);
         b = longint'(q);
      end
      r = a * b;
      return r[2*W-1:0];
   endfunction

   // One full transaction; checks latency, busy/done shape and the product.
   task automatic do_op(input logic [W-1:0] m, input logic [W-1:0] q, input logic sgn,
                        output logic [2*W-1:0] p);
      int lat;
      int exp_lat;
      logic eff_sgn;
      eff_sgn = HAS_U ? sgn : 1'b1;
      exp_lat = eff_sgn ? W : W + 1;
      @(negedge clk);
      start = 1'b1;
      multiplicand = m;
      multiplier = q;
      is_signed = sgn;
      @(posedge clk);
      #1;
      start = 1'b0;
      multiplicand = W'($urandom);
      multiplier = W'($urandom);
      is_signed = 1'(~sgn);
      check("busy_after_accept", 64'(busy), 64'(1));
      lat = 0;
      while (!done && lat < 3 * W) begin
         @(posedge clk);
         #1;
         lat++;
         if (!done) check("busy_in_run", 64'(busy), 64'(1));
      end
      check("latency", 64'(lat), 64'(exp_lat));
      check("busy_with_done", 64'(busy), 64'(1));
      check("product", 64'(product), 64'(ref_mul(m, q, eff_sgn)));
      p = product;
      @(posedge clk);
      #1;
      check("done_one_cycle", 64'(done), 64'(0));
      check("busy_fall", 64'(busy), 64'(0));
      check("product_held", 64'(product), 64'(p));
   endtask

   initial begin
      logic [2*W-1:0] p;
      logic [2*W-1:0] first_p;
      int             n_done;
      int             stamps[$];

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_product", 64'(product), 64'(0));
      rst_n = 1'b1;

      // Directed values
      do_op(4'd3, 4'd5, 1'b1, p);
      check("3x5", 64'(p), 64'(8'h0F));
      do_op(4'h8, 4'h8, 1'b1, p);
      check("m8xm8", 64'(p), 64'(8'h40));
      do_op(4'hD, 4'd7, 1'b1, p);
      check("m3x7", 64'(p), 64'(8'hEB));
      do_op(4'd7, 4'hF, 1'b1, p);
      check("7xm1", 64'(p), 64'(8'hF9));

      // Exhaustive signed sweep
      for (int i = 0; i < (1 << W); i++)
         for (int j = 0; j < (1 << W); j++)
            do_op(W'(i), W'(j), 1'b1, p);

`ifdef BOOTH_UNSIGNED_EN
      do_op(4'd15, 4'd15, 1'b0, p);
      check("u15x15", 64'(p), 64'(8'hE1));
      do_op(4'd15, 4'd15, 1'b1, p);
      check("s15x15", 64'(p), 64'(8'h01));
      for (int i = 0; i < (1 << W); i++)
         for (int j = 0; j < (1 << W); j++)
            do_op(W'(i), W'(j), 1'b0, p);
`endif

      // Random operands, mode and idle gaps
      for (int k = 0; k < 200; k++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         do_op(W'($urandom), W'($urandom), HAS_U ? 1'($urandom) : 1'b1, p);
      end

      // start pulsed during RUN is ignored
      do_op(4'd3, 4'd5, 1'b1, first_p);
      @(negedge clk);
      start = 1'b1;
      multiplicand = 4'd3;
      multiplier = 4'd5;
      is_signed = 1'b1;
      @(negedge clk);
      multiplicand = 4'd7;
      multiplier = 4'd6;
      @(negedge clk);
      start = 1'b0;
      n_done = 0;
      p = '0;
      for (int i = 0; i < 2 * W + 4; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            n_done++;
            p = product;
         end
      end
      check("ignore_start_dones", 64'(n_done), 64'(1));
      check("ignore_start_product", 64'(p), 64'(8'h0F));

      // Reset mid-RUN: immediate clear, no done, clean restart
      @(negedge clk);
      start = 1'b1;
      multiplicand = 4'hD;
      multiplier = 4'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_busy", 64'(busy), 64'(0));
      check("midrst_done", 64'(done), 64'(0));
      check("midrst_product", 64'(product), 64'(0));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      n_done = 0;
      for (int i = 0; i < 2 * W + 4; i++) begin
         @(posedge clk);
         #1;
         if (done) n_done++;
      end
      check("midrst_no_done", 64'(n_done), 64'(0));
      do_op(4'hD, 4'd7, 1'b1, p);
      check("after_rst", 64'(p), 64'(8'hEB));

      // start held high: back-to-back operations at full throughput
      @(negedge clk);
      start = 1'b1;
      multiplicand = 4'hA;
      multiplier = 4'd6;
      is_signed = 1'b1;
      for (int i = 0; i < 8 * W && stamps.size() < 3; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            stamps.push_back(cyc);
            check("b2b_product", 64'(product), 64'(8'hDC));
         end
      end
      start = 1'b0;
      check("b2b_count", 64'(stamps.size()), 64'(3));
      if (stamps.size() == 3) begin
         check("b2b_period0", 64'(stamps[1] - stamps[0]), 64'(W + 2));
         check("b2b_period1", 64'(stamps[2] - stamps[1]), 64'(W + 2));
      end
      for (int i = 0; i < 3 * W && busy; i++) begin
         @(posedge clk);
         #1;
      end
      check("b2b_idle", 64'(busy), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
